// File: rtl/event_tally_sequencer.sv
// rtl/event_tally_sequencer.sv - windowed rising-edge tally feeding the 2-bit status/count register stage
module event_tally_sequencer #(
    parameter int WINDOW = 16,
    parameter int TW     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       event_in,
    output logic       status,
    output logic [1:0] count,
    output logic       busy,
    output logic       overflow,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    // Timer counts down to zero, so loading WINDOW-1 gives exactly WINDOW COUNT cycles.
    localparam logic [TW-1:0] TIMER_LOAD = TW'(WINDOW - 1);

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] timer;
    logic [1:0]    tally;
    logic          s1;
    logic          s2;
    logic          s3;
    logic          ev_edge;

    // Two-flop synchronizer for the raw event line plus a history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= event_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign ev_edge = s2 & ~s3;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and Moore outputs; outputs depend only on the registered state
    // so an asynchronous reset forces status high and count to zero immediately.
    always_comb begin
        state_nx = state;
        status   = 1'b1;
        busy     = 1'b0;
        done     = 1'b0;
        count    = 2'b00;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = COUNT;
                end
            end
            COUNT: begin
                status = 1'b0;
                busy   = 1'b1;
                if (timer == '0) begin
                    state_nx = REPORT;
                end
            end
            REPORT: begin
                status   = 1'b0;
                busy     = 1'b1;
                done     = 1'b1;
                count    = tally;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Window timer, saturating tally and sticky overflow; all cleared by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer    <= '0;
            tally    <= 2'b00;
            overflow <= 1'b0;
        end else if (state == IDLE && start) begin
            timer    <= TIMER_LOAD;
            tally    <= 2'b00;
            overflow <= 1'b0;
        end else if (state == COUNT) begin
            timer <= timer - TW'(1);
            if (ev_edge) begin
                if (tally != 2'b11) begin
                    tally <= tally + 2'd1;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/event_tally_sequencer.md
Name: event_tally_sequencer

Overview:
- Upstream feeder for the 2-bit status/count register stage.
- Samples an asynchronous event line over a fixed window of clock cycles and tallies rising edges, saturating at 3.
- Drives `status` low while a window is active.
- Presents the tally on `count` for exactly one cycle at window end, then raises `status` so the downstream register sees a rising edge and clears.

Parameters:
- WINDOW, 16, length of the counting window in clk cycles; legal range 1..2^TW.
- TW, 8, width of the window timer in bits.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to open a counting window; sampled in IDLE only.
- event_in  input  1  asynchronous raw event line.
- status  output  1  1 = idle/clear (downstream held cleared), 0 = window active or reporting.
- count  output  2  tally code; 2'b00 except during the REPORT cycle.
- busy  output  1  1 in COUNT and REPORT.
- overflow  output  1  sticky; set when more than 3 edges are seen in a window.
- done  output  1  single-cycle pulse in REPORT.

Behaviour:
- Reset (rst_n=0, asynchronous, at any time including mid-window):
  - state=IDLE, status=1, count=2'b00, busy=0, overflow=0, done=0.
  - tally=0, timer=0, all three sync flops=0.
- Input conditioning:
  - event_in passes through two synchronizer flops (s1, s2), then a history flop s3.
  - edge = s2 & ~s3.
  - Latency: an event_in rising edge registered at cycle N produces edge=1 in cycle N+2.
- State machine (registered, Moore outputs):
  - IDLE:
    - status=1, busy=0, count=00.
    - start=1 → COUNT; timer loaded with WINDOW-1; tally cleared; overflow cleared.
  - COUNT:
    - status=0, busy=1, count=00.
    - Every cycle with edge=1: if tally<3, tally+1; else overflow←1 and tally holds at 3.
    - timer decrements each cycle; when timer==0 in this cycle → REPORT.
    - COUNT therefore lasts exactly WINDOW cycles.
  - REPORT (exactly 1 cycle):
    - status=0, busy=1, done=1, count=tally.
    - Next state IDLE; status rises on the following edge.
- Arithmetic: tally is 2 bits and never wraps (3 is terminal). Timer is TW bits, unsigned, loaded from WINDOW-1 truncated to TW.
- Boundary conditions:
  - start while busy: ignored; no restart, no queuing.
  - start held high continuously: a new window begins the cycle after return to IDLE, so IDLE lasts one cycle and status pulses high for one cycle.
  - Edge on the final COUNT cycle (timer==0): counted.
  - Edges in IDLE or REPORT: ignored, but the sync chain still runs.
  - WINDOW=1: COUNT lasts one cycle.
  - overflow stays set through REPORT and IDLE until the next accepted start.
  - Reset asserted during REPORT: count drops to 00 and status rises immediately (asynchronous); no done pulse is completed.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, no start → status=1, count=00, busy=0 indefinitely.
- Single event, WINDOW=16: start pulse, one event_in pulse 4 cycles long mid-window → 16 cycles with status=0, then one REPORT cycle with count=01 and done=1, then status=1.
- Saturation: 5 separated event pulses in a window → REPORT count=11, overflow=1; overflow remains 1 in IDLE; next start clears it to 0.
- Last-cycle edge: time the edge so edge=1 on the timer==0 cycle with 1 prior event → count=10.
- start during COUNT, and start held high: extra pulses cause no change in window length; held start yields back-to-back windows with status high for exactly 1 cycle between them.
- Mid-window reset: 2 edges counted, rst_n low at cycle 8 → immediate status=1, count=00, busy=0; after release, a new start yields a tally starting from 0.
